// File: rtl/mul_rr_arbiter_if.sv
// Bundle of requester, multiplier and response signals for mul_rr_arbiter.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface mul_rr_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int OUTPUT_WIDTH = 32
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_val;
  logic [NUM_REQ-1:0]                 req_rdy;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_x;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_y;
  logic [DATA_WIDTH-1:0]              mul_x;
  logic [DATA_WIDTH-1:0]              mul_y;
  logic [OUTPUT_WIDTH-1:0]            mul_c;
  logic                               resp_val;
  logic                               resp_rdy;
  logic [IDW-1:0]                     resp_id;
  logic [OUTPUT_WIDTH-1:0]            resp_data;

  modport slave (
    input  req_val, req_x, req_y, mul_c, resp_rdy,
    output req_rdy, mul_x, mul_y, resp_val, resp_id, resp_data
  );

  modport master (
    output req_val, req_x, req_y, mul_c, resp_rdy,
    input  req_rdy, mul_x, mul_y, resp_val, resp_id, resp_data
  );
endinterface

// File: rtl/mul_rr_arbiter.sv
// Round-robin front end that shares one fixed-latency, stall-less multiplier.
// Each issued op carries its requester id down a tag pipeline, and its product is
// captured in a response FIFO. Issue is credit-gated, so every product in flight
// already owns a FIFO slot.
module mul_rr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int OUTPUT_WIDTH = 32,
  parameter int MUL_LAT      = 1,
  parameter int RESP_DEPTH   = 4
) (
  input logic             clk,
  input logic             reset_n,
  mul_rr_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW  = $clog2(RESP_DEPTH + MUL_LAT + 1) + 1;

  logic [IDW-1:0]              ptr_q, ptr_d;
  logic [MUL_LAT-1:0]          tag_vld_q, tag_vld_d;
  logic [MUL_LAT-1:0][IDW-1:0] tag_id_q, tag_id_d;
  logic [CW-1:0]               inflight_q, inflight_d;
  logic [CW-1:0]               count_q, count_d;
  logic [PW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [OUTPUT_WIDTH-1:0]     mem_q    [RESP_DEPTH];
  logic [IDW-1:0]              mem_id_q [RESP_DEPTH];

  logic                  found, credit_ok, fire, push, pop, head_vld;
  logic [IDW-1:0]        grant_idx;
  logic [DATA_WIDTH-1:0] sel_x, sel_y;

  // Credit counts only registered occupancy; a pop frees its slot one cycle later.
  assign credit_ok = (count_q + inflight_q) < CW'(RESP_DEPTH);
  // Gating with reset_n keeps req_rdy low for the whole time reset is asserted.
  assign fire      = found & credit_ok & reset_n;
  assign push      = tag_vld_q[MUL_LAT-1];
  assign head_vld  = (count_q != '0);
  assign pop       = head_vld & bus.resp_rdy;

  // Pick the first active requester, searching upward from the rotating pointer.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && bus.req_val[IDW'(idx)]) begin
        found     = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  // Decode the one-hot grant and steer the winner's operands to the multiplier.
  always_comb begin
    bus.req_rdy = '0;
    sel_x       = '0;
    sel_y       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fire && grant_idx == IDW'(i)) begin
        bus.req_rdy[i] = 1'b1;
        sel_x          = bus.req_x[i];
        sel_y          = bus.req_y[i];
      end
    end
  end

  assign bus.mul_x = sel_x;
  assign bus.mul_y = sel_y;

  // Next state: rr pointer, tag shift register, credit and FIFO bookkeeping.
  always_comb begin
    ptr_d = ptr_q;
    if (fire) ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);

    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = fire;
    tag_id_d[0]  = grant_idx;
    for (int s = 1; s < MUL_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end

    inflight_d = inflight_q + CW'(fire) - CW'(push);
    count_d    = count_q + CW'(push) - CW'(pop);

    wr_d = wr_q;
    if (push) wr_d = (wr_q == PW'(RESP_DEPTH - 1)) ? '0 : wr_q + PW'(1);
    rd_d = rd_q;
    if (pop)  rd_d = (rd_q == PW'(RESP_DEPTH - 1)) ? '0 : rd_q + PW'(1);
  end

  // Control state. Reset drops every tag and every buffered result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      ptr_q      <= ptr_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  // FIFO storage needs no reset, because the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q]    <= bus.mul_c;
      mem_id_q[wr_q] <= tag_id_q[MUL_LAT-1];
    end
  end

  assign bus.resp_val  = head_vld;
  assign bus.resp_id   = head_vld ? mem_id_q[rd_q] : '0;
  assign bus.resp_data = head_vld ? mem_q[rd_q]    : '0;
endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Directed bench for mul_rr_arbiter with a registered multiplier model and a response scoreboard.
module tb_mul_rr_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int OW = 32;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } resp_t;

  // Products of the default operands: x = i+2, y = 10+i.
  localparam logic [31:0] PROD [NR] = '{32'd20, 32'd33, 32'd48, 32'd65};

  logic  clk = 1'b0;
  logic  reset_n = 1'b0;
  int    checks = 0;
  int    errors = 0;
  resp_t exp_q[$];

  always #5 clk = ~clk;

  mul_rr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW)) bus ();

  mul_rr_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .MUL_LAT(1), .RESP_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // External multiplier: one register stage, no reset, truncated to OW bits.
  always @(posedge clk) bus.mul_c <= bus.mul_x * bus.mul_y;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every accepted response must match the scoreboard head.
  always @(negedge clk) begin
    resp_t e;
    if (reset_n && bus.resp_val && bus.resp_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got id %0d data %0h expected none", bus.resp_id, bus.resp_data);
      end else begin
        e = exp_q.pop_front();
        check("resp_id", 64'(bus.resp_id), 64'(e.id));
        check("resp_data", 64'(bus.resp_data), 64'(e.data));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive req_val for one cycle, check the grant, and queue the expected product.
  task automatic issue(input logic [3:0] val, input logic [3:0] exp_rdy, input string name);
    bus.req_val = val;
    @(negedge clk);
    check(name, 64'(bus.req_rdy), 64'(exp_rdy));
    for (int i = 0; i < NR; i++)
      if (exp_rdy[i]) exp_q.push_back('{id: 2'(i), data: PROD[i]});
    cyc();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.resp_rdy = 1'b1;
    for (int i = 0; i < NR; i++) begin
      bus.req_x[i] = DW'(i + 2);
      bus.req_y[i] = DW'(10 + i);
    end

    // Reset state, with all requesters active so that grant gating is exercised.
    bus.req_val = '1;
    @(negedge clk);
    check("rst_req_rdy", 64'(bus.req_rdy), 64'd0);
    check("rst_resp_val", 64'(bus.resp_val), 64'd0);
    check("rst_mul_x", 64'(bus.mul_x), 64'd0);
    check("rst_resp_id", 64'(bus.resp_id), 64'd0);
    check("rst_resp_data", 64'(bus.resp_data), 64'd0);
    bus.req_val = '0;
    cyc();
    reset_n = 1'b1;

    // Single op from requester 2, with a two-cycle response latency.
    bus.req_x[2] = 32'd3;
    bus.req_y[2] = 32'd5;
    bus.req_val  = 4'b0100;
    @(negedge clk);
    check("t1_rdy", 64'(bus.req_rdy), 64'h4);
    check("t1_mul_x", 64'(bus.mul_x), 64'd3);
    check("t1_mul_y", 64'(bus.mul_y), 64'd5);
    exp_q.push_back('{id: 2'd2, data: 32'd15});
    cyc();
    bus.req_val = '0;
    @(negedge clk);
    check("t1_val_early", 64'(bus.resp_val), 64'd0);
    cyc();
    @(negedge clk);
    check("t1_val_t2", 64'(bus.resp_val), 64'd1);
    cyc();
    bus.req_x[2] = 32'd4;
    bus.req_y[2] = 32'd12;
    drain();

    // Full contention: grants rotate 0,1,2,3 at one per cycle.
    do_reset();
    for (int k = 0; k < 8; k++) issue(4'hF, 4'(1 << (k % 4)), "t2_grant");
    bus.req_val = '0;
    drain();

    // Pointer wrap: move ptr to 2, then 4'b1010 grants 3 first and then 1.
    do_reset();
    issue(4'b0010, 4'b0010, "t3_setup");
    issue(4'b1010, 4'b1000, "t3_first");
    issue(4'b0010, 4'b0010, "t3_second");
    issue(4'b1111, 4'b0100, "t3_ptr_at_2");
    bus.req_val = '0;
    drain();

    // Truncation of the product (ptr is 3, so requester 0 wins).
    bus.req_x[0] = 32'hFFFF_FFFF;
    bus.req_y[0] = 32'd2;
    bus.req_val  = 4'b0001;
    @(negedge clk);
    check("t5_rdy", 64'(bus.req_rdy), 64'h1);
    exp_q.push_back('{id: 2'd0, data: 32'hFFFF_FFFE});
    cyc();
    bus.req_val  = '0;
    bus.req_x[0] = 32'd2;
    bus.req_y[0] = 32'd10;
    drain();

    // Backpressure: exactly RESP_DEPTH grants, then one pop buys exactly one more.
    do_reset();
    bus.resp_rdy = 1'b0;
    for (int k = 0; k < 4; k++) issue(4'hF, 4'(1 << k), "t4_grant");
    for (int k = 0; k < 3; k++) begin
      bus.req_val = 4'hF;
      @(negedge clk);
      check("t4_stall_rdy", 64'(bus.req_rdy), 64'd0);
      check("t4_stall_mul_x", 64'(bus.mul_x), 64'd0);
      check("t4_head_val", 64'(bus.resp_val), 64'd1);
      check("t4_head_id", 64'(bus.resp_id), 64'd0);
      cyc();
    end
    bus.resp_rdy = 1'b1;
    @(negedge clk);
    check("t4_pop_cycle_rdy", 64'(bus.req_rdy), 64'd0);
    cyc();
    bus.resp_rdy = 1'b0;
    issue(4'hF, 4'b0001, "t4_regrant");
    @(negedge clk);
    check("t4_full_again", 64'(bus.req_rdy), 64'd0);
    cyc();
    bus.req_val  = '0;
    bus.resp_rdy = 1'b1;
    drain();

    // Async reset with one result buffered, one in the multiplier and one firing.
    bus.resp_rdy = 1'b0;
    bus.req_val  = 4'hF;
    cyc();
    cyc();
    @(negedge clk);
    check("t6_pre_val", 64'(bus.resp_val), 64'd1);
    check("t6_pre_fire", 64'(bus.req_rdy != '0), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_val", 64'(bus.resp_val), 64'd0);
    check("t6_rst_rdy", 64'(bus.req_rdy), 64'd0);
    bus.req_val = '0;
    cyc();
    cyc();
    reset_n      = 1'b1;
    bus.resp_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t6_no_stale", 64'(bus.resp_val), 64'd0);
      cyc();
    end
    issue(4'hF, 4'b0001, "t6_first_grant");
    bus.req_val = '0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
